usb_tx_pkt_sequencer: RTL and testbench

// - Parametrised USB full-speed TX packet sequencer; successor to the single-size TX controller.
// - Accepts a packet request plus payload from the endpoint TX FIFO (show-ahead).
// - Emits SYNC, PID, payload and CRC16 as a byte stream to the bit shifter/stuffer, then requests EOP.
// - Supports DATA0/DATA1/ACK/NAK/STALL, payloads of 0..MAX_PAYLOAD bytes, abort and size-error reporting.

---
 rtl/usb_tx_pkg.sv | 28 ++
 rtl/usb_crc16_byte.sv | 21 ++
 rtl/usb_tx_pkt_sequencer.sv | 97 +++++++++
 tb/tb_usb_tx_pkt_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB full-speed TX packet sequencer
package usb_tx_pkg;
  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_pkt_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_DRAIN, ST_EOP
  } state_e;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  // PID byte on the wire is {~pid, pid}; only legal codes ever reach this
  function automatic logic [7:0] pid_byte(input logic [2:0] p);
    return p == PKT_DATA0 ? PID_DATA0 :
           p == PKT_DATA1 ? PID_DATA1 :
           p == PKT_ACK   ? PID_ACK   :
           p == PKT_NAK   ? PID_NAK   : PID_STALL;
  endfunction
endpackage

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: reflected CRC16 (0x8005) register updated one byte per cycle
// Ports: clk, n_rst (async, active-low); clr reloads init; en folds data into crc; crc is the raw register
import usb_tx_pkg::*;
module usb_crc16_byte (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  logic [15:0] nxt;
  always_comb begin
    nxt = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ CRC16_POLY_R : nxt >> 1;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) crc <= CRC16_INIT;
    else if (clr) crc <= CRC16_INIT;
    else if (en) crc <= nxt;
endmodule

// File: rtl/usb_tx_pkt_sequencer.sv
// usb_tx_pkt_sequencer: emits SYNC, PID, payload and CRC16 bytes for one USB FS packet, then requests EOP
// Ports: clk, n_rst (async, active-low)
//   request : tx_packet, tx_size, tx_abort; FIFO: tx_packet_data, get_tx_packet_data
//   shifter : byte_data, byte_valid, byte_ready, shift_busy; encoder: eop_start, eop_done
//   status  : tx_busy, tx_done, tx_error
import usb_tx_pkg::*;
module usb_tx_pkt_sequencer #(
  parameter int          MAX_PAYLOAD = 64,
  parameter int          SIZE_W      = 7,
  parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        tx_packet,
  input  logic [SIZE_W-1:0] tx_size,
  input  logic [7:0]        tx_packet_data,
  output logic              get_tx_packet_data,
  input  logic              tx_abort,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  input  logic              shift_busy,
  output logic              eop_start,
  input  logic              eop_done,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error
);
  state_e state, nxt;
  logic [2:0] pkt;
  logic [SIZE_W-1:0] size, cnt;
  logic aborted;
  logic [15:0] crc;
  logic xfer, legal, too_big, can_take, accept, size_err, abort_hit, last;
  assign xfer      = byte_valid & byte_ready;
  assign legal     = tx_packet inside {[3'd1:3'd5]};
  assign too_big   = (tx_packet == PKT_DATA0 || tx_packet == PKT_DATA1) && tx_size > SIZE_W'(MAX_PAYLOAD);
  // a request arriving with the finishing eop_done is taken on the same edge
  assign can_take  = state == ST_IDLE || (state == ST_EOP && eop_done);
  assign accept    = can_take & legal & ~too_big;
  assign size_err  = can_take & legal & too_big;
  assign abort_hit = tx_abort && state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI};
  assign last      = cnt + SIZE_W'(1) == size;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   nxt = accept ? ST_SYNC : ST_IDLE;
      ST_SYNC:   nxt = xfer ? ST_PID : ST_SYNC;
      ST_PID:    nxt = !xfer ? ST_PID : pkt > PKT_DATA1 ? ST_DRAIN : size == '0 ? ST_CRC_LO : ST_DATA;
      ST_DATA:   nxt = xfer && last ? ST_CRC_LO : ST_DATA;
      ST_CRC_LO: nxt = xfer ? ST_CRC_HI : ST_CRC_LO;
      ST_CRC_HI: nxt = xfer ? ST_DRAIN : ST_CRC_HI;
      ST_DRAIN:  nxt = shift_busy ? ST_DRAIN : ST_EOP;
      ST_EOP:    nxt = !eop_done ? ST_EOP : accept ? ST_SYNC : ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (abort_hit) nxt = ST_DRAIN;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      {pkt, size, cnt, aborted, tx_error, eop_start} <= '0;
    end else begin
      tx_error  <= size_err | abort_hit;
      eop_start <= state == ST_DRAIN && !shift_busy;
      if (accept) begin
        pkt     <= tx_packet;
        size    <= tx_size;
        cnt     <= '0;
        aborted <= 1'b0;
      end else begin
        if (abort_hit) aborted <= 1'b1;
        if (get_tx_packet_data) cnt <= cnt + SIZE_W'(1);
      end
    end
  always_comb begin
    byte_valid         = state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI};
    byte_data          = state == ST_SYNC   ? SYNC_BYTE :
                         state == ST_PID    ? pid_byte(pkt) :
                         state == ST_DATA   ? tx_packet_data :
                         state == ST_CRC_LO ? ~crc[7:0] :
                         state == ST_CRC_HI ? ~crc[15:8] : 8'h00;
    get_tx_packet_data = state == ST_DATA && byte_ready;
    tx_busy            = state != ST_IDLE;
    tx_done            = state == ST_EOP && eop_done && !aborted;
  end
  usb_crc16_byte u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (state == ST_EOP && eop_done),
    .en    (get_tx_packet_data),
    .data  (tx_packet_data),
    .crc   (crc)
  );
endmodule

// File: tb/tb_usb_tx_pkt_sequencer.sv
// tb_usb_tx_pkt_sequencer: directed self-checking bench for usb_tx_pkt_sequencer
module tb_usb_tx_pkt_sequencer;
  logic clk, n_rst;
  logic [2:0] tx_packet;
  logic [6:0] tx_size;
  logic [7:0] tx_packet_data;
  logic get_tx_packet_data, tx_abort;
  logic [7:0] byte_data;
  logic byte_valid, byte_ready, shift_busy, eop_start, eop_done;
  logic tx_busy, tx_done, tx_error;
  int tests = 0, fails = 0;
  int pops, eops, dones, errs, valids, cyc = 0, eop_cyc, sb_fall;
  logic stall = 0;
  logic [7:0] fifo[$];
  logic [7:0] got[$];
  logic [15:0] c;
  logic [7:0] d, pid;
  logic fb;
  int n;
  usb_tx_pkt_sequencer dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .tx_size(tx_size),
    .tx_packet_data(tx_packet_data), .get_tx_packet_data(get_tx_packet_data),
    .tx_abort(tx_abort), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .shift_busy(shift_busy), .eop_start(eop_start),
    .eop_done(eop_done), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_bytes(input string tag, input int cnt, input logic [103:0] e);
    chk($sformatf("%s len", tag), got.size(), cnt);
    for (int i = 0; i < cnt; i++)
      chk($sformatf("%s[%0d]", tag, i), i < got.size() ? got[i] : 8'hxx, e[8*(cnt-1-i) +: 8]);
  endtask
  task automatic clr();
    got.delete();
    pops = 0; eops = 0; dones = 0; errs = 0; valids = 0;
    eop_cyc = -1; sb_fall = -5;
  endtask
  task automatic send(input logic [2:0] p, input logic [6:0] s);
    tx_packet = p; tx_size = s;
    @(posedge clk); #1;
    tx_packet = 0;
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (tx_busy && k < 300) begin @(posedge clk); #1; k++; end
    chk({tag, " idle"}, tx_busy, 0);
  endtask
  // monitor plus shifter, FIFO and EOP-encoder models, all in one clocked loop
  initial begin
    int sb = 0, ec = 0;
    logic xf, pp, es, psb = 0, pv = 0, pr = 0;
    logic [7:0] pd = 0;
    tx_packet_data = 0; shift_busy = 0; eop_done = 0; byte_ready = 1;
    forever begin
      @(posedge clk);
      cyc++;
      xf = byte_valid & byte_ready; pp = get_tx_packet_data; es = eop_start;
      if (xf) got.push_back(byte_data);
      if (pp) pops++;
      if (es) begin eops++; eop_cyc = cyc; end
      if (psb && !shift_busy) sb_fall = cyc;
      if (tx_done) dones++;
      if (tx_error) errs++;
      if (byte_valid) valids++;
      if (pv && !pr && byte_valid) chk("stable", byte_data, pd);
      psb = shift_busy; pv = byte_valid; pr = byte_ready; pd = byte_data;
      #1;
      if (!n_rst) begin
        sb = 0; ec = 0;
      end else begin
        if (pp && fifo.size() != 0) void'(fifo.pop_front());
        sb = xf ? 3 : sb != 0 ? sb - 1 : 0;
        ec = es ? 3 : ec != 0 ? ec - 1 : 0;
      end
      tx_packet_data = fifo.size() != 0 ? fifo[0] : 8'h00;
      shift_busy = sb != 0;
      eop_done = ec == 1;
      byte_ready = stall ? $urandom_range(0, 1) != 0 : 1'b1;
    end
  end
  initial begin
    n_rst = 1; tx_packet = 0; tx_size = 0; tx_abort = 0;
    #3 n_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst byte_valid", byte_valid, 0);
    chk("rst byte_data", byte_data, 0);
    chk("rst tx_busy", tx_busy, 0);
    chk("rst get", get_tx_packet_data, 0);
    chk("rst eop_start", eop_start, 0);
    chk("rst tx_done", tx_done, 0);
    chk("rst tx_error", tx_error, 0);
    n_rst = 1;
    repeat (2) @(posedge clk);
    #1;
    // DATA0, empty payload
    clr();
    send(3'd1, 0);
    chk("d0z busy", tx_busy, 1);
    chk("d0z valid", byte_valid, 1);
    chk("d0z sync", byte_data, 8'h80);
    wait_idle("d0z");
    chk_bytes("d0z", 4, {8'h80, 8'hC3, 8'h00, 8'h00});
    chk("d0z eop timing", eop_cyc, sb_fall + 1);
    chk("d0z eops", eops, 1);
    chk("d0z dones", dones, 1);
    chk("d0z pops", pops, 0);
    chk("d0z errs", errs, 0);
    // DATA1, 4 bytes, random ready stalls
    clr();
    for (int i = 0; i < 4; i++) fifo.push_back(8'(i));
    stall = 1;
    send(3'd2, 4);
    wait_idle("d1");
    stall = 0;
    c = 16'hFFFF;
    for (int b = 0; b < 4; b++) begin
      d = 8'(b);
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ d[j];
        c = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
      end
    end
    chk_bytes("d1", 8, {8'h80, 8'h4B, 8'h00, 8'h01, 8'h02, 8'h03, ~c[7:0], ~c[15:8]});
    chk("d1 pops", pops, 4);
    chk("d1 dones", dones, 1);
    // DATA0 "123456789": CRC-16/USB check value B4C8, low byte first
    clr();
    for (int i = 0; i < 9; i++) fifo.push_back(8'(8'h31 + i));
    send(3'd1, 9);
    wait_idle("chk");
    chk_bytes("chk", 13, {8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                          8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4});
    chk("chk pops", pops, 9);
    // handshakes
    for (int k = 0; k < 3; k++) begin
      clr();
      pid = k == 0 ? 8'hD2 : k == 1 ? 8'h5A : 8'h1E;
      send(3'(3 + k), 0);
      wait_idle("hs");
      chk_bytes($sformatf("hs%0d", k), 2, {8'h80, pid});
      chk("hs pops", pops, 0);
      chk("hs eops", eops, 1);
      chk("hs dones", dones, 1);
    end
    // oversize DATA request
    clr();
    send(3'd1, 65);
    chk("big tx_error", tx_error, 1);
    chk("big tx_busy", tx_busy, 0);
    chk("big valid", byte_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("big errs", errs, 1);
    chk("big valids", valids, 0);
    chk("big eops", eops, 0);
    // abort together with the 10th payload transfer
    clr();
    for (int i = 0; i < 64; i++) fifo.push_back(8'(i));
    send(3'd1, 64);
    n = 0;
    while (pops != 9 && n < 100) begin @(posedge clk); #1; n++; end
    chk("abt reach", pops, 9);
    tx_abort = 1;
    @(posedge clk); #1;
    tx_abort = 0;
    chk("abt valid", byte_valid, 0);
    chk("abt tx_error", tx_error, 1);
    wait_idle("abt");
    chk("abt pops", pops, 10);
    chk("abt bytes", got.size(), 12);
    chk("abt errs", errs, 1);
    chk("abt eops", eops, 1);
    chk("abt dones", dones, 0);
    fifo.delete();
    // request while busy is ignored
    clr();
    send(3'd4, 0);
    tx_packet = 3'd3;
    @(posedge clk); #1;
    tx_packet = 0;
    wait_idle("bsy");
    chk_bytes("bsy", 2, {8'h80, 8'h5A});
    chk("bsy dones", dones, 1);
    chk("bsy eops", eops, 1);
    // reset mid-payload
    clr();
    for (int i = 0; i < 8; i++) fifo.push_back(8'(8'hA0 + i));
    send(3'd1, 8);
    n = 0;
    while (pops != 3 && n < 100) begin @(posedge clk); #1; n++; end
    chk("mrst reach", pops, 3);
    n_rst = 0;
    #1;
    chk("mrst valid", byte_valid, 0);
    chk("mrst busy", tx_busy, 0);
    chk("mrst get", get_tx_packet_data, 0);
    chk("mrst data", byte_data, 0);
    chk("mrst eop_start", eop_start, 0);
    @(posedge clk); #1;
    n_rst = 1;
    fifo.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mrst no eop", eops, 0);
    clr();
    send(3'd3, 0);
    wait_idle("post");
    chk_bytes("post", 2, {8'h80, 8'hD2});
    chk("post dones", dones, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
